// File: rtl/q_frag_bank_ctrl.sv
// Two-requester sequencer for a bank of Q_FRAG fragments: arbitrates, drives
// QEN/QDI/QST/QRT/CDS with fixed pulse/recovery timing, and returns FAQZ.
module q_frag_bank_ctrl #(
  parameter int W     = 8,
  parameter int PULSE = 1,
  parameter int REC   = 2
) (
  input  logic         qck_i,
  input  logic         qrt_i,
  input  logic         req_a_i,
  input  logic [1:0]   op_a_i,
  input  logic [W-1:0] mask_a_i,
  input  logic [W-1:0] data_a_i,
  input  logic         req_b_i,
  input  logic [1:0]   op_b_i,
  input  logic [W-1:0] mask_b_i,
  input  logic [W-1:0] data_b_i,
  output logic         gnt_a_o,
  output logic         gnt_b_o,
  output logic         done_a_o,
  output logic         done_b_o,
  output logic [W-1:0] rdata_o,
  output logic [W-1:0] fqen_o,
  output logic [W-1:0] fqdi_o,
  output logic [W-1:0] fqst_o,
  output logic [W-1:0] fqrt_o,
  output logic         fcds_o,
  input  logic [W-1:0] faqz_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_ASYNC = 3'd2,
    S_RECOV = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] mask_q, mask_d, data_q, data_d;
  logic         owner_q, owner_d;  // 1 = B owns the command in flight
  logic         rr_q, rr_d;        // 1 = B wins the next tie
  logic [15:0]  cnt_q, cnt_d;
  logic         gnt_a_d, gnt_b_d, done_a_d, done_b_d, fcds_d;
  logic [W-1:0] rdata_d, fqen_d, fqdi_d, fqst_d, fqrt_d;
  logic         accept_s, win_b_s;

  // Arbitration, sequencing and next-value decode of every registered output.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mask_d   = mask_q;
    data_d   = data_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_o;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    fqen_d   = '0;
    fqdi_d   = '0;
    fqst_d   = '0;
    fqrt_d   = '0;
    fcds_d   = 1'b0;
    accept_s = ((state_q == S_IDLE) || (state_q == S_DONE)) && (req_a_i || req_b_i);
    win_b_s  = req_b_i && (!req_a_i || rr_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          op_d    = win_b_s ? op_b_i   : op_a_i;
          mask_d  = win_b_s ? mask_b_i : mask_a_i;
          data_d  = win_b_s ? data_b_i : data_a_i;
          owner_d = win_b_s;
          rr_d    = !win_b_s;
          gnt_a_d = !win_b_s;
          gnt_b_d = win_b_s;
          cnt_d   = 16'(PULSE - 1);
          case (op_d)
            2'b00:   state_d = S_CAPT;
            2'b01:   state_d = S_WRITE;
            default: state_d = S_ASYNC;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: state_d = S_CAPT;
      S_ASYNC: begin
        if (cnt_q == 16'd0) begin
          // With no recovery cycles, CAPT itself is the quiet gap.
          if (REC == 0) begin
            state_d = S_CAPT;
          end else begin
            state_d = S_RECOV;
            cnt_d   = 16'(REC - 1);
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RECOV: begin
        if (cnt_q == 16'd0) begin
          state_d = S_CAPT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CAPT: begin
        state_d  = S_DONE;
        rdata_d  = faqz_i;
        done_a_d = !owner_q;
        done_b_d = owner_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Pins follow the state being entered so they are valid for its whole cycle.
    case (state_d)
      S_WRITE: begin
        fqen_d = mask_d;
        fqdi_d = data_d & mask_d;
        fcds_d = 1'b1;
      end
      S_ASYNC: begin
        if (op_d == 2'b10) begin
          fqst_d = mask_d;
        end else begin
          fqrt_d = mask_d;
        end
      end
      default: fcds_d = 1'b0;
    endcase
  end

  // State, command latch and registered outputs with synchronous reset.
  always_ff @(posedge qck_i) begin
    if (qrt_i) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      mask_q   <= '0;
      data_q   <= '0;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      cnt_q    <= 16'd0;
      gnt_a_o  <= 1'b0;
      gnt_b_o  <= 1'b0;
      done_a_o <= 1'b0;
      done_b_o <= 1'b0;
      rdata_o  <= '0;
      fqen_o   <= '0;
      fqdi_o   <= '0;
      fqst_o   <= '0;
      fqrt_o   <= '0;
      fcds_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      gnt_a_o  <= gnt_a_d;
      gnt_b_o  <= gnt_b_d;
      done_a_o <= done_a_d;
      done_b_o <= done_b_d;
      rdata_o  <= rdata_d;
      fqen_o   <= fqen_d;
      fqdi_o   <= fqdi_d;
      fqst_o   <= fqst_d;
      fqrt_o   <= fqrt_d;
      fcds_o   <= fcds_d;
    end
  end

endmodule

// File: tb/tb_q_frag_bank_ctrl.sv
// Directed bench for q_frag_bank_ctrl: default instance plus a PULSE=3/REC=0
// instance, each driving a small behavioural Q_FRAG bank.
module tb_q_frag_bank_ctrl;

  logic       clk = 1'b0;
  logic       qrt;
  logic       req_a, req_b;
  logic [1:0] op_a, op_b;
  logic [7:0] mask_a, data_a, mask_b, data_b;
  logic       gnt_a, gnt_b, done_a, done_b, fcds;
  logic [7:0] rdata, fqen, fqdi, fqst, fqrt, bank;

  logic       req2;
  logic [1:0] op2;
  logic [7:0] mask2;
  logic       gnt2_a, gnt2_b, done2_a, done2_b, fcds2;
  logic [7:0] rdata2, fqen2, fqdi2, fqst2, fqrt2, bank2;

  int checks = 0;
  int failures = 0;
  logic [7:0] overlap;

  always #5 clk = ~clk;

  q_frag_bank_ctrl #(.W(8), .PULSE(1), .REC(2)) dut (
    .qck_i(clk), .qrt_i(qrt),
    .req_a_i(req_a), .op_a_i(op_a), .mask_a_i(mask_a), .data_a_i(data_a),
    .req_b_i(req_b), .op_b_i(op_b), .mask_b_i(mask_b), .data_b_i(data_b),
    .gnt_a_o(gnt_a), .gnt_b_o(gnt_b), .done_a_o(done_a), .done_b_o(done_b),
    .rdata_o(rdata), .fqen_o(fqen), .fqdi_o(fqdi), .fqst_o(fqst), .fqrt_o(fqrt),
    .fcds_o(fcds), .faqz_i(bank)
  );

  q_frag_bank_ctrl #(.W(8), .PULSE(3), .REC(0)) dut2 (
    .qck_i(clk), .qrt_i(qrt),
    .req_a_i(req2), .op_a_i(op2), .mask_a_i(mask2), .data_a_i(8'h00),
    .req_b_i(1'b0), .op_b_i(2'b00), .mask_b_i(8'h00), .data_b_i(8'h00),
    .gnt_a_o(gnt2_a), .gnt_b_o(gnt2_b), .done_a_o(done2_a), .done_b_o(done2_b),
    .rdata_o(rdata2), .fqen_o(fqen2), .fqdi_o(fqdi2), .fqst_o(fqst2), .fqrt_o(fqrt2),
    .fcds_o(fcds2), .faqz_i(bank2)
  );

  // Behavioural fragments: clear beats set beats clocked load.
  initial begin
    bank  = 8'h00;
    bank2 = 8'h00;
  end
  always @(posedge clk) begin
    bank  <= (((fqen & fqdi) | (~fqen & bank)) | fqst) & ~fqrt;
    bank2 <= (((fqen2 & fqdi2) | (~fqen2 & bank2)) | fqst2) & ~fqrt2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    overlap = overlap | (fqst & fqrt) | (fqst2 & fqrt2);
  endtask

  initial begin
    overlap = 8'h00;
    qrt = 1'b1;
    req_a = 1'b1; op_a = 2'b01; mask_a = 8'hFF; data_a = 8'hA5;
    req_b = 1'b0; op_b = 2'b00; mask_b = 8'h00; data_b = 8'h00;
    req2 = 1'b0; op2 = 2'b00; mask2 = 8'h00;

    // Reset held two cycles with REQ_A high
    tick();
    tick();
    check("rst_gnt", {gnt_a, gnt_b, done_a, done_b}, 4'b0000);
    check("rst_pins", {fqen, fqdi, fqst, fqrt}, 32'h0);
    check("rst_rdata_fcds", {rdata, fcds}, 9'h000);
    qrt = 1'b0;

    // Write 0xA5, full mask
    tick();
    req_a = 1'b0;
    check("wr_gnt", {gnt_a, gnt_b}, 2'b10);
    check("wr_fqen", fqen, 8'hFF);
    check("wr_fqdi", fqdi, 8'hA5);
    check("wr_fcds", fcds, 1'b1);
    tick();
    check("wr_capt_pins", {fqen, fcds, gnt_a, done_a}, 11'h000);
    tick();
    check("wr_done", {done_a, done_b}, 2'b10);
    check("wr_rdata", rdata, 8'hA5);

    // B reads back, accepted in A's DONE cycle
    req_b = 1'b1; op_b = 2'b00;
    tick();
    req_b = 1'b0;
    check("rd_gnt", {gnt_a, gnt_b}, 2'b01);
    tick();
    check("rd_done", {done_a, done_b}, 2'b01);
    check("rd_rdata", rdata, 8'hA5);

    // A clears low nibble
    req_a = 1'b1; op_a = 2'b11; mask_a = 8'h0F;
    tick();
    req_a = 1'b0;
    check("clr_pulse", {fqrt, fqst}, 16'h0F00);
    check("clr_gnt", gnt_a, 1'b1);
    tick();
    check("clr_rec1", {fqrt, fqst}, 16'h0000);
    tick();
    check("clr_rec2", {fqrt, fqst}, 16'h0000);
    tick();
    check("clr_early_done", done_a, 1'b0);
    tick();
    check("clr_done", done_a, 1'b1);
    check("clr_rdata", rdata, 8'hA0);

    // B sets bits 5:4
    req_b = 1'b1; op_b = 2'b10; mask_b = 8'h30;
    tick();
    req_b = 1'b0;
    check("set_pulse", {fqst, fqrt}, 16'h3000);
    check("set_gnt", gnt_b, 1'b1);
    tick();
    check("set_rec1", {fqst, fqrt}, 16'h0000);
    tick();
    tick();
    check("set_early_done", done_b, 1'b0);
    tick();
    check("set_done", {done_a, done_b}, 2'b01);
    check("set_rdata", rdata, 8'hB0);

    // Continuous contention with reads: grants alternate A, B, A, B
    req_a = 1'b1; op_a = 2'b00; mask_a = 8'h00;
    req_b = 1'b1; op_b = 2'b00; mask_b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        check($sformatf("cont_gnt%0d", i / 2), {gnt_a, gnt_b}, ((i / 2) % 2 == 0) ? 2'b10 : 2'b01);
      end else begin
        check($sformatf("cont_done%0d", i / 2), {done_a, done_b}, ((i / 2) % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (i == 6) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
    tick();
    check("cont_idle", {gnt_a, gnt_b, done_a, done_b}, 4'b0000);

    // Reset in the middle of a set pulse
    req_a = 1'b1; op_a = 2'b10; mask_a = 8'h0F;
    tick();
    check("mid_pulse", fqst, 8'h0F);
    qrt = 1'b1;
    req_b = 1'b1; op_b = 2'b00;
    tick();
    check("mid_rst_fqst", fqst, 8'h00);
    check("mid_rst_rdata", rdata, 8'h00);
    check("mid_rst_flags", {gnt_a, gnt_b, done_a, done_b}, 4'b0000);
    tick();
    check("mid_rst_hold", {gnt_a, gnt_b, done_a, done_b, fqst}, 12'h000);
    qrt = 1'b0;
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    check("mid_ptr_a", {gnt_a, gnt_b}, 2'b10);
    for (int i = 0; i < 4; i++) tick();
    check("mid_redo_done", {done_a, done_b}, 2'b10);
    check("mid_redo_rdata", rdata, 8'hBF);

    // Write with empty mask leaves bank untouched
    req_a = 1'b1; op_a = 2'b01; mask_a = 8'h00; data_a = 8'hFF;
    tick();
    req_a = 1'b0;
    check("m0_gnt", gnt_a, 1'b1);
    check("m0_fqen", {fqen, fqdi}, 16'h0000);
    tick();
    tick();
    check("m0_done", done_a, 1'b1);
    check("m0_rdata", rdata, 8'hBF);

    // PULSE=3, REC=0 instance: set 0x81
    req2 = 1'b1; op2 = 2'b10; mask2 = 8'h81;
    tick();
    req2 = 1'b0;
    check("p3_gnt", gnt2_a, 1'b1);
    check("p3_st1", fqst2, 8'h81);
    tick();
    check("p3_st2", fqst2, 8'h81);
    tick();
    check("p3_st3", fqst2, 8'h81);
    tick();
    check("p3_gap", {fqst2, fqrt2, fqen2}, 24'h0);
    check("p3_early_done", done2_a, 1'b0);
    tick();
    check("p3_done", done2_a, 1'b1);
    check("p3_rdata", rdata2, 8'h81);

    check("no_st_rt_overlap", overlap, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_frag_bank_ctrl.md
# q_frag_bank_ctrl

Sequencing and arbitration controller for a bank of `W` Q_FRAG flip-flop fragments. It is shared between two requesters, A and B, and serialises their commands: clocked masked write, asynchronous set, asynchronous clear, and readback. It generates the fragment control pins (QEN/QDI/QST/QRT/CDS) with guaranteed pulse widths and recovery gaps, then returns the sampled fragment outputs. It sits between fabric-level configuration/test logic and the Q_FRAG bank, which runs its QCK from the same clock.

## Interface
- `W`, default 8: number of fragments in the bank, and the width of all data, mask and fragment buses.
- `PULSE`, default 1: number of cycles that set/clear is held on FQST/FQRT. Legal range is 1 or more.
- `REC`, default 2: number of idle recovery cycles after set/clear is released and before capture. Legal range is 0 or more.
- `QCK  in  1`: the single clock. It is also the fragments' QCK.
- `QRT  in  1`: reset. **One clock; reset is synchronous and active-high.**
- `REQ_A  in  1`: request from A. Held until granted.
- `OP_A  in  2`: command from A. 00 = read, 01 = write, 10 = set, 11 = clear.
- `MASK_A  in  W`: per-fragment select for A.
- `DATA_A  in  W`: write data for A.
- `REQ_B  in  1`, `OP_B  in  2`, `MASK_B  in  W`, `DATA_B  in  W`: the same fields for requester B.
- `GNT_A  out  1`, `GNT_B  out  1`: one-cycle acceptance pulse.
- `DONE_A  out  1`, `DONE_B  out  1`: one-cycle completion pulse.
- `RDATA  out  W`: FAQZ snapshot. Valid in the DONE cycle and held until the next capture.
- `FQEN  out  W`, `FQDI  out  W`, `FQST  out  W`, `FQRT  out  W`, `FCDS  out  1`: drive the fragments' QEN, QDI, QST, QRT and CDS. QSTS and QRTS are tied 0 externally.
- `FAQZ  in  W`: fragment AQZ outputs.

## Operation
- **States:** IDLE, WRITE, ASYNC, RECOV, CAPT, DONE. All outputs are registered.
- **Acceptance and arbitration:**
  - A request can be accepted only in IDLE or DONE, which gives back-to-back throughput.
  - If only one REQ is high, that requester wins.
  - If both are high, the requester named by the round-robin pointer wins. The pointer is A after reset and switches to the other requester after every grant.
  - At acceptance the controller latches OP, MASK, DATA and the owner. The GNT of the winner pulses in the following cycle.
  - A REQ arriving in any other state is ignored; the requester keeps it held.
- **Transitions out of the accept:**
  - op 01 → WRITE
  - op 10 or 11 → ASYNC
  - op 00 → CAPT
- **WRITE (1 cycle):**
  - FQEN = MASK, FQDI = DATA & MASK, FCDS = 1.
  - The fragments capture on the closing edge.
  - Next state is CAPT.
- **ASYNC (PULSE cycles):**
  - Set drives FQST = MASK; clear drives FQRT = MASK.
  - Next state is RECOV, or CAPT if REC = 0.
- **RECOV (REC cycles):**
  - All fragment outputs are 0.
  - Next state is CAPT.
- **CAPT (1 cycle):**
  - RDATA ← FAQZ on the closing edge.
  - Next state is DONE.
- **DONE (1 cycle):**
  - DONE of the owner pulses and RDATA is valid.
  - Next state is IDLE, unless a new accept happens in this cycle.
- **Invariants, checked every cycle:**
  - FQST & FQRT == 0.
  - FQEN is nonzero only in WRITE; FCDS is high only in WRITE.
  - FQST/FQRT are nonzero only in ASYNC.
  - At most one of each GNT/DONE pair is high.
- **MASK = 0:** the full sequence still runs with no fragment pin active, and RDATA still refreshes.
- **Reset (QRT high at an edge, including mid-operation):**
  - State → IDLE and pointer → A.
  - All outputs → 0, including RDATA, GNT_*, DONE_*, FQ* and FCDS.
  - The in-flight command is dropped with no DONE.
  - FQRT is not pulsed, so fragment contents are untouched by controller reset.

## Timing
Cycle 0 is the cycle in which REQ is accepted. Latency from REQ to DONE:
- **GNT:** cycle 1.
- **Read:** CAPT is cycle 1, DONE is cycle 2.
- **Write:** WRITE is cycle 1, CAPT is cycle 2, DONE is cycle 3. RDATA shows the new values.
- **Set/clear:**
  - ASYNC occupies cycles 1..PULSE.
  - RECOV occupies the next REC cycles.
  - CAPT is cycle PULSE+REC+1 and DONE is cycle PULSE+REC+2.
  - With the defaults, DONE is cycle 5.
- **Throughput:** a new command can be accepted in the DONE cycle, so commands issue with no idle gap.
- **Fragment recovery:** there is always at least one cycle with FQST = FQRT = 0 before any following WRITE. In the REC = 0 case the CAPT cycle provides this gap.

## Test plan
- **Reset:** hold QRT for 2 cycles with REQ_A high → all outputs 0, no GNT, state IDLE. After release, GNT_A arrives one cycle after the first accept.
- **Write then readback:** A issues write with MASK=0xFF, DATA=0xA5 → GNT_A at +1, FQEN=0xFF and FCDS=1 at +1 only, DONE_A at +3 with RDATA=0xA5. B then issues read → RDATA=0xA5 at DONE_B, +2.
- **Set/clear:** with the bank at 0xA5, clear with MASK=0x0F gives 0xA0; set with MASK=0x30 gives 0xB0.
  - FQRT/FQST are high for exactly PULSE cycles, followed by REC zero cycles.
  - DONE arrives at +5 with the defaults.
  - FQST & FQRT is never nonzero.
- **Contention:** REQ_A and REQ_B held together continuously → grants alternate A, B, A, B with back-to-back accepts in the DONE cycles, and every DONE matches its GNT owner.
- **Reset mid-command:** assert QRT during ASYNC of a set → no DONE; FQST is 0 at the next edge; RDATA is 0; the pointer returns to A.
- **Edge parameters:** with REC=0 and PULSE=3, a set completes with DONE at +5. With MASK=0, a write completes at +3 with FQEN=0 and RDATA equal to the prior bank value.
